// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between the configuration host and the chain loader.
interface ccff_chain_loader_if #(
   parameter int unsigned WORD_W = 8
);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes host bitstream words LSB-first into a tile ccff chain; in verify
// mode it compares bits falling out of ccff_tail with the bits being shifted in.
module ccff_chain_loader #(
   parameter int unsigned CHAIN_LEN = 64,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 prog_clk,
   input  logic                 prog_reset,
   input  logic                 cmd_load,
   input  logic                 cmd_verify,
   ccff_chain_loader_if.slave   cfg,
   output logic                 ccff_head,
   output logic                 ccff_shift_en,
   input  logic                 ccff_tail,
   output logic                 busy,
   output logic                 done,
   output logic                 verify_err,
   output logic [CNT_W-1:0]     mismatch_cnt
);

   localparam int unsigned BCNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;
   typedef enum logic {MODE_LOAD, MODE_VERIFY} mode_t;

   state_t              state, state_d;
   mode_t               mode, mode_d;
   logic [WORD_W-1:0]   word, word_d;
   logic [IDX_W-1:0]    idx, idx_d;
   logic [BCNT_W-1:0]   bit_cnt, bit_cnt_d;
   logic                ready_q, ready_d;
   logic                head_d, shift_en_d, busy_d, done_d, err_d;
   logic [CNT_W-1:0]    mcnt_d;

   assign cfg.cfg_ready = ready_q;

   // State and registered outputs
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state         <= IDLE;
         mode          <= MODE_LOAD;
         word          <= '0;
         idx           <= '0;
         bit_cnt       <= '0;
         ready_q       <= 1'b0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         verify_err    <= 1'b0;
         mismatch_cnt  <= '0;
      end else begin
         state         <= state_d;
         mode          <= mode_d;
         word          <= word_d;
         idx           <= idx_d;
         bit_cnt       <= bit_cnt_d;
         ready_q       <= ready_d;
         ccff_head     <= head_d;
         ccff_shift_en <= shift_en_d;
         busy          <= busy_d;
         done          <= done_d;
         verify_err    <= err_d;
         mismatch_cnt  <= mcnt_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state;
      mode_d     = mode;
      word_d     = word;
      idx_d      = idx;
      bit_cnt_d  = bit_cnt;
      head_d     = ccff_head;
      shift_en_d = 1'b0;
      done_d     = 1'b0;
      err_d      = verify_err;
      mcnt_d     = mismatch_cnt;

      // The bit leaving ccff_tail on a shift edge is the k-th bit of the old stream
      if (ccff_shift_en && (mode == MODE_VERIFY) && (ccff_tail != ccff_head)) begin
         err_d = 1'b1;
         if (mismatch_cnt != {CNT_W{1'b1}}) begin
            mcnt_d = mismatch_cnt + CNT_W'(1);
         end
      end

      unique case (state)
         IDLE: begin
            if (cmd_load) begin
               state_d   = FETCH;
               mode_d    = MODE_LOAD;
               bit_cnt_d = '0;
            end else if (cmd_verify) begin
               state_d   = FETCH;
               mode_d    = MODE_VERIFY;
               bit_cnt_d = '0;
               err_d     = 1'b0;
               mcnt_d    = '0;
            end
         end
         FETCH: begin
            if (cfg.cfg_valid && ready_q) begin
               word_d  = cfg.cfg_data;
               idx_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            head_d     = word[idx];
            shift_en_d = 1'b1;
            bit_cnt_d  = bit_cnt + BCNT_W'(1);
            idx_d      = idx + IDX_W'(1);
            // A full chain ends the pass even mid-word; leftover bits are dropped
            if (bit_cnt_d == BCNT_W'(CHAIN_LEN)) begin
               state_d = FINISH;
            end else if (idx == IDX_W'(WORD_W - 1)) begin
               state_d = FETCH;
            end
         end
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == FETCH);
      busy_d  = (state_d != IDLE);
   end

endmodule
